timed_mux: RTL and testbench

- Two-input time-division multiplexer.
- A free-running slot timer alternates the selected channel between d0 and d1; each channel is held for a programmable number of clock cycles.
- The selected input is registered onto out, giving a one-cycle latency.
- Sits between two data sources and a shared single-lane sink, such as a serialised status line or a shared probe pin.

---
 rtl/timed_mux.sv | 71 +++++++
 tb/tb_timed_mux.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timed_mux.sv
// timed_mux: two-input time-division multiplexer.
// A free-running slot timer alternates between d0 (DWELL0 cycles) and
// d1 (DWELL1 cycles). The selected input is registered onto out, so out
// lags sel by one cycle.
// Optional build macro: TIMED_MUX_FREEZE_EN adds a freeze input that
// holds the timer and the data register.
module timed_mux #(
  parameter int W      = 1,
  parameter int DWELL0 = 1,
  parameter int DWELL1 = 1,
  parameter int CNT_W  = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
`ifdef TIMED_MUX_FREEZE_EN
  input  logic         freeze,
`endif
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  output logic [W-1:0] out,
  output logic         sel,
  output logic         slot_start
);

  // Last count value of each slot, truncated to the counter width.
  localparam logic [CNT_W-1:0] LAST0 = CNT_W'(DWELL0 - 1);
  localparam logic [CNT_W-1:0] LAST1 = CNT_W'(DWELL1 - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last;
  logic             hold;

  // Terminal count for the slot in progress, plus the global hold request.
  always_comb begin
    last = sel ? LAST1 : LAST0;
`ifdef TIMED_MUX_FREEZE_EN
    hold = freeze;
`else
    hold = 1'b0;
`endif
  end

  // Slot timer: count while enabled, swap channel on the terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      sel        <= 1'b0;
      slot_start <= 1'b0;
    end else if (hold || !en) begin
      slot_start <= 1'b0;
    end else if (cnt == last) begin
      cnt        <= '0;
      sel        <= ~sel;
      slot_start <= 1'b1;
    end else begin
      cnt        <= cnt + 1'b1;
      slot_start <= 1'b0;
    end
  end

  // Data path: register the channel selected before this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= '0;
    end else if (!hold) begin
      out <= sel ? d1 : d0;
    end
  end

endmodule

// File: tb/tb_timed_mux.sv
// tb_timed_mux: randomized self-checking bench for timed_mux.
// Two instances run side by side on shared stimulus: u_a (DWELL 1/1) and
// u_b (DWELL 3/2). The reference model tracks the number of enabled edges
// since reset and derives the channel from its position in the slot period.
// Build with TIMED_MUX_FREEZE_EN to also exercise the freeze input.
module tb_timed_mux;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         freeze;
  logic [W-1:0] d0, d1;
  logic [W-1:0] a_out, b_out;
  logic         a_sel, b_sel, a_ss, b_ss;

  int total = 0;
  int bad   = 0;

  // Reference model state: enabled-edge counts and registered outputs.
  int           ka, kb;
  logic [W-1:0] ma_out, mb_out;
  logic         ma_ss, mb_ss;

  always #5 clk = ~clk;

  timed_mux #(.W(W), .DWELL0(1), .DWELL1(1), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .en(en),
`ifdef TIMED_MUX_FREEZE_EN
    .freeze(freeze),
`endif
    .d0(d0), .d1(d1), .out(a_out), .sel(a_sel), .slot_start(a_ss)
  );

  timed_mux #(.W(W), .DWELL0(3), .DWELL1(2), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .en(en),
`ifdef TIMED_MUX_FREEZE_EN
    .freeze(freeze),
`endif
    .d0(d0), .d1(d1), .out(b_out), .sel(b_sel), .slot_start(b_ss)
  );

  // Channel selected after k enabled edges: position within the period.
  function automatic logic msel(input int k, input int dw0, input int dw1);
    return (k % (dw0 + dw1)) >= dw0;
  endfunction

  // A new slot begins exactly when the position wraps or reaches dw0.
  function automatic logic mstart(input int k, input int dw0, input int dw1);
    int pos;
    pos = k % (dw0 + dw1);
    return (pos == 0) || (pos == dw0);
  endfunction

  task automatic model_reset();
    ka = 0; kb = 0;
    ma_out = '0; mb_out = '0;
    ma_ss = 1'b0; mb_ss = 1'b0;
  endtask

  // Advance one clock edge and update the model from the pre-edge inputs.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (freeze) begin
      ma_ss = 1'b0; mb_ss = 1'b0;
    end else begin
      ma_out = msel(ka, 1, 1) ? d1 : d0;
      mb_out = msel(kb, 3, 2) ? d1 : d0;
      if (en) begin
        ka++; kb++;
        ma_ss = mstart(ka, 1, 1);
        mb_ss = mstart(kb, 3, 2);
      end else begin
        ma_ss = 1'b0; mb_ss = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; freeze = 1'b0; d0 = '0; d1 = '0;
    model_reset();
    step(); step();
    rst = 1'b0; en = 1'b1; d0 = 4'hF; d1 = 4'hF;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if ({a_out, a_sel, a_ss, b_out, b_sel, b_ss} !==
          {ma_out, msel(ka, 1, 1), ma_ss, mb_out, msel(kb, 3, 2), mb_ss}) begin
        bad++;
        $display("FAIL reset_pre cyc=%0d got a=%h/%b/%b b=%h/%b/%b exp a=%h/%b/%b b=%h/%b/%b", i,
                 a_out, a_sel, a_ss, b_out, b_sel, b_ss,
                 ma_out, msel(ka, 1, 1), ma_ss, mb_out, msel(kb, 3, 2), mb_ss);
      end
    end
    // Assert reset between edges; outputs must clear without a clock edge.
    #2 rst = 1'b1;
    #1;
    total++;
    if ({a_out, a_sel, a_ss, b_out, b_sel, b_ss} !== {4'h0, 2'b00, 4'h0, 2'b00}) begin
      bad++;
      $display("FAIL reset_async got a=%h/%b/%b b=%h/%b/%b exp all zero",
               a_out, a_sel, a_ss, b_out, b_sel, b_ss);
    end
    model_reset();
    step();
    rst = 1'b0;
    // First slot after release must be channel 0 for its full dwell.
    for (int i = 0; i < 3; i++) begin
      total++;
      if (b_sel !== 1'b0) begin
        bad++;
        $display("FAIL reset_first_slot cyc=%0d got sel=%b exp 0", i, b_sel);
      end
      step();
    end
    total++;
    if (b_sel !== 1'b1 || b_ss !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_switch got sel=%b ss=%b exp 1/1", b_sel, b_ss);
    end
  endtask

  task automatic test_dwell1();
    do_reset();
    en = 1'b1; d0 = 4'h0; d1 = 4'h1;
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if ({a_out, a_sel, a_ss} !== {ma_out, msel(ka, 1, 1), ma_ss}) begin
        bad++;
        $display("FAIL dwell1 cyc=%0d got out=%h sel=%b ss=%b exp out=%h sel=%b ss=%b",
                 i, a_out, a_sel, a_ss, ma_out, msel(ka, 1, 1), ma_ss);
      end
    end
  endtask

  task automatic test_dwell32();
    logic [9:0] pat;
    pat = 10'b0001100011;  // sel per cycle, cycle 0 in the MSB
    do_reset();
    en = 1'b1; d0 = 4'h1; d1 = 4'h0;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (b_sel !== pat[9 - i] || b_out !== mb_out || b_ss !== mb_ss) begin
        bad++;
        $display("FAIL dwell32 cyc=%0d got sel=%b out=%h ss=%b exp sel=%b out=%h ss=%b",
                 i, b_sel, b_out, b_ss, pat[9 - i], mb_out, mb_ss);
      end
      step();
    end
  endtask

  task automatic test_en_hold();
    do_reset();
    en = 1'b1; d0 = 4'h3; d1 = 4'hC;
    step();  // u_b now one cycle into channel 0
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d0 = 4'($urandom);
      d1 = 4'($urandom);
      step();
      total++;
      if ({b_out, b_sel, b_ss} !== {mb_out, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL en_hold cyc=%0d got out=%h sel=%b ss=%b exp out=%h sel=0 ss=0",
                 i, b_out, b_sel, b_ss, mb_out);
      end
    end
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if ({b_out, b_sel, b_ss} !== {mb_out, msel(kb, 3, 2), mb_ss}) begin
        bad++;
        $display("FAIL en_resume cyc=%0d got out=%h sel=%b ss=%b exp out=%h sel=%b ss=%b",
                 i, b_out, b_sel, b_ss, mb_out, msel(kb, 3, 2), mb_ss);
      end
    end
  endtask

  task automatic test_patterns();
    do_reset();
    en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      d0 = (c & 2) != 0 ? 4'hF : 4'h0;
      d1 = (c & 1) != 0 ? 4'hF : 4'h0;
      for (int i = 0; i < 10; i++) begin
        step();
        total++;
        if ({a_out, b_out} !== {ma_out, mb_out} || (c == 3 && i > 0 && {a_out, b_out} !== 8'hFF)) begin
          bad++;
          $display("FAIL patterns c=%0d cyc=%0d got a=%h b=%h exp a=%h b=%h",
                   c, i, a_out, b_out, ma_out, mb_out);
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 200; i++) begin
      en = ($urandom_range(0, 3) != 0);
      d0 = 4'($urandom);
      d1 = 4'($urandom);
      step();
      total++;
      if ({a_out, a_sel, a_ss, b_out, b_sel, b_ss} !==
          {ma_out, msel(ka, 1, 1), ma_ss, mb_out, msel(kb, 3, 2), mb_ss}) begin
        bad++;
        $display("FAIL random cyc=%0d got a=%h/%b/%b b=%h/%b/%b exp a=%h/%b/%b b=%h/%b/%b", i,
                 a_out, a_sel, a_ss, b_out, b_sel, b_ss,
                 ma_out, msel(ka, 1, 1), ma_ss, mb_out, msel(kb, 3, 2), mb_ss);
      end
    end
  endtask

`ifdef TIMED_MUX_FREEZE_EN
  task automatic test_freeze();
    do_reset();
    en = 1'b1; d0 = 4'h5; d1 = 4'hA;
    step();
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d0 = 4'($urandom);
      d1 = 4'($urandom);
      step();
      total++;
      if ({b_out, b_sel, b_ss, a_out, a_sel, a_ss} !==
          {mb_out, msel(kb, 3, 2), 1'b0, ma_out, msel(ka, 1, 1), 1'b0}) begin
        bad++;
        $display("FAIL freeze cyc=%0d got a=%h/%b/%b b=%h/%b/%b exp a=%h/%b/0 b=%h/%b/0", i,
                 a_out, a_sel, a_ss, b_out, b_sel, b_ss,
                 ma_out, msel(ka, 1, 1), mb_out, msel(kb, 3, 2));
      end
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({a_out, a_sel, a_ss, b_out, b_sel, b_ss} !== {4'h0, 2'b00, 4'h0, 2'b00}) begin
      bad++;
      $display("FAIL freeze_reset got a=%h/%b/%b b=%h/%b/%b exp all zero",
               a_out, a_sel, a_ss, b_out, b_sel, b_ss);
    end
    model_reset();
    step();
    rst = 1'b0;
    freeze = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if ({b_out, b_sel, b_ss} !== {mb_out, msel(kb, 3, 2), mb_ss}) begin
        bad++;
        $display("FAIL freeze_after cyc=%0d got out=%h sel=%b ss=%b exp out=%h sel=%b ss=%b",
                 i, b_out, b_sel, b_ss, mb_out, msel(kb, 3, 2), mb_ss);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_dwell1();
    test_dwell32();
    test_en_hold();
    test_patterns();
    test_random();
`ifdef TIMED_MUX_FREEZE_EN
    test_freeze();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
